// File: rtl/event_conv2d_engine_if.sv
// Event handshake plus kernel/neuron BRAM port bundle for the event conv engine.
// master = the engine side, slave = the FIFO/BRAM environment side.
interface event_conv2d_engine_if #(
  parameter int COORD_BITS             = 8,
  parameter int IN_CHANNELS            = 2,
  parameter int OUT_CHANNELS           = 4,
  parameter int IMG_WIDTH              = 32,
  parameter int IMG_HEIGHT             = 32,
  parameter int BITS_PER_NEURON        = 9,
  parameter int BITS_PER_KERNEL_WEIGHT = 6,
  parameter int KERNEL_SIZE            = 3
);
  localparam int CH_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int KW_AW = (IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE > 1) ?
                         $clog2(IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE) : 1;
  localparam int NM_AW = (IMG_WIDTH*IMG_HEIGHT > 1) ? $clog2(IMG_WIDTH*IMG_HEIGHT) : 1;

  logic                                             evt_valid;
  logic                                             evt_ready;
  logic [COORD_BITS-1:0]                            evt_x;
  logic [COORD_BITS-1:0]                            evt_y;
  logic [CH_W-1:0]                                  evt_ch;
  logic                                             kw_en;
  logic [KW_AW-1:0]                                 kw_addr;
  logic [OUT_CHANNELS*BITS_PER_KERNEL_WEIGHT-1:0]   kw_rdata;
  logic                                             nm_ren;
  logic                                             nm_wen;
  logic [NM_AW-1:0]                                 nm_addr;
  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]          nm_rdata;
  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0]          nm_wdata;
  logic                                             busy;
  logic                                             done;
  logic                                             coord_err;

  modport master (
    input  evt_valid, evt_x, evt_y, evt_ch, kw_rdata, nm_rdata,
    output evt_ready, kw_en, kw_addr, nm_ren, nm_wen, nm_addr, nm_wdata,
           busy, done, coord_err
  );

  modport slave (
    output evt_valid, evt_x, evt_y, evt_ch, kw_rdata, nm_rdata,
    input  evt_ready, kw_en, kw_addr, nm_ren, nm_wen, nm_addr, nm_wdata,
           busy, done, coord_err
  );
endinterface

// File: rtl/event_conv2d_engine.sv
// Event-driven KxK convolution scatter: one spike event updates all output
// channels of each in-bounds neighbour by read-modify-write with saturation.
module event_conv2d_lane #(
  parameter int N = 9,
  parameter int W = 6
) (
  input  logic [N-1:0] pot,
  input  logic [W-1:0] wt,
  output logic [N-1:0] sum
);
  logic [N:0] acc;

  // N+1-bit sum: overflow shows as the top two bits disagreeing
  assign acc = {pot[N-1], pot} + {{(N+1-W){wt[W-1]}}, wt};

  always_comb begin
    sum = acc[N-1:0];
    if (acc[N] != acc[N-1])
      sum = acc[N] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  end
endmodule

module event_conv2d_engine #(
  parameter int COORD_BITS             = 8,
  parameter int IN_CHANNELS            = 2,
  parameter int OUT_CHANNELS           = 4,
  parameter int IMG_WIDTH              = 32,
  parameter int IMG_HEIGHT             = 32,
  parameter int BITS_PER_NEURON        = 9,
  parameter int BITS_PER_KERNEL_WEIGHT = 6,
  parameter int KERNEL_SIZE            = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  event_conv2d_engine_if.master bus
);
  localparam int CH_W  = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
  localparam int KW_AW = (IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE > 1) ?
                         $clog2(IN_CHANNELS*KERNEL_SIZE*KERNEL_SIZE) : 1;
  localparam int NM_AW = (IMG_WIDTH*IMG_HEIGHT > 1) ? $clog2(IMG_WIDTH*IMG_HEIGHT) : 1;
  localparam int KC_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam int SW    = COORD_BITS + 2;
  localparam int P     = KERNEL_SIZE / 2;
  localparam int L     = OUT_CHANNELS;
  localparam int N     = BITS_PER_NEURON;
  localparam int W     = BITS_PER_KERNEL_WEIGHT;

  localparam logic signed [SW-1:0] P_S    = SW'(P);
  localparam logic signed [SW-1:0] IW_S   = SW'(IMG_WIDTH);
  localparam logic signed [SW-1:0] IH_S   = SW'(IMG_HEIGHT);
  localparam logic [COORD_BITS:0]  IW_C   = (COORD_BITS+1)'(IMG_WIDTH);
  localparam logic [COORD_BITS:0]  IH_C   = (COORD_BITS+1)'(IMG_HEIGHT);
  localparam logic [KC_W-1:0]      K_LAST = KC_W'(KERNEL_SIZE-1);

  typedef enum logic [1:0] {IDLE, SCAN, UPDATE, DONE} state_t;

  state_t                state;
  logic [KC_W-1:0]       kx, ky;
  logic [COORD_BITS-1:0] x_q, y_q;
  logic [CH_W-1:0]       ch_q;
  logic                  evt_ready_q, busy_q, done_q, coord_err_q;

  logic signed [SW-1:0]  ox, oy;
  logic                  pos_in, last, step, rd, addr_on, evt_oob;
  logic [NM_AW-1:0]      nm_lin;
  logic [KW_AW-1:0]      kw_lin;
  logic [L-1:0][N-1:0]   lane_sum;

  // Zero-extended coordinates plus two bits of headroom make ox/oy signed-safe
  assign ox = $signed({2'b00, x_q}) - P_S + $signed({{(SW-KC_W){1'b0}}, kx});
  assign oy = $signed({2'b00, y_q}) - P_S + $signed({{(SW-KC_W){1'b0}}, ky});

  assign pos_in  = !ox[SW-1] && (ox < IW_S) && !oy[SW-1] && (oy < IH_S);
  assign last    = (kx == K_LAST) && (ky == K_LAST);
  assign step    = ((state == SCAN) && !pos_in) || (state == UPDATE);
  assign rd      = (state == SCAN) && pos_in;
  assign addr_on = ((state == SCAN) || (state == UPDATE)) && pos_in;
  assign evt_oob = ({1'b0, bus.evt_x} >= IW_C) || ({1'b0, bus.evt_y} >= IH_C);

  assign nm_lin = NM_AW'(oy) * NM_AW'(IMG_WIDTH) + NM_AW'(ox);
  assign kw_lin = KW_AW'(ch_q) * KW_AW'(KERNEL_SIZE*KERNEL_SIZE)
                + KW_AW'(ky) * KW_AW'(KERNEL_SIZE) + KW_AW'(kx);

  for (genvar c = 0; c < L; c++) begin : g_lane
    event_conv2d_lane #(.N(N), .W(W)) u_lane (
      .pot (bus.nm_rdata[c*N +: N]),
      .wt  (bus.kw_rdata[c*W +: W]),
      .sum (lane_sum[c])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      kx          <= '0;
      ky          <= '0;
      x_q         <= '0;
      y_q         <= '0;
      ch_q        <= '0;
      evt_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      coord_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      coord_err_q <= 1'b0;
      unique case (state)
        IDLE: if (bus.evt_valid) begin
          x_q         <= bus.evt_x;
          y_q         <= bus.evt_y;
          ch_q        <= bus.evt_ch;
          kx          <= '0;
          ky          <= '0;
          evt_ready_q <= 1'b0;
          busy_q      <= 1'b1;
          if (evt_oob) begin
            state       <= DONE;
            done_q      <= 1'b1;
            coord_err_q <= 1'b1;
          end else begin
            state <= SCAN;
          end
        end
        SCAN: if (pos_in) state <= UPDATE;
        DONE: begin
          state       <= IDLE;
          evt_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: ;
      endcase
      // Advance past a skipped position or a completed write
      if (step) begin
        if (last) begin
          state  <= DONE;
          done_q <= 1'b1;
        end else begin
          state <= SCAN;
          if (kx == K_LAST) begin
            kx <= '0;
            ky <= ky + 1'b1;
          end else begin
            kx <= kx + 1'b1;
          end
        end
      end
    end
  end

  assign bus.evt_ready = evt_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.coord_err = coord_err_q;
  assign bus.kw_en     = rd;
  assign bus.nm_ren    = rd;
  assign bus.nm_wen    = (state == UPDATE);
  assign bus.kw_addr   = rd ? kw_lin : '0;
  assign bus.nm_addr   = addr_on ? nm_lin : '0;
  assign bus.nm_wdata  = (state == UPDATE) ? lane_sum : '0;
endmodule

// File: tb/tb_event_conv2d_engine.sv
// Directed bench for event_conv2d_engine with 1-cycle BRAM models.
module tb_event_conv2d_engine;
  localparam int L = 4;
  localparam int N = 9;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  event_conv2d_engine_if bus ();
  event_conv2d_engine dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [L*W-1:0] kw_mem [32];
  logic [L*N-1:0] nm_mem [1024];
  logic [9:0]     wr_log [256];
  logic [4:0]     kw_log [256];
  int             wr_n = 0;
  int             rd_n = 0;
  int             kw_n = 0;
  logic           pre_clr, pre_we;
  logic [9:0]     pre_addr;
  logic [L*N-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_clr) for (int i = 0; i < 1024; i++) nm_mem[i] = '0;
    if (pre_we) nm_mem[pre_addr] = pre_data;
    if (bus.kw_en) begin
      bus.kw_rdata <= kw_mem[bus.kw_addr];
      kw_log[8'(kw_n)] = bus.kw_addr;
      kw_n++;
    end
    if (bus.nm_ren) begin
      bus.nm_rdata <= nm_mem[bus.nm_addr];
      rd_n++;
    end
    if (bus.nm_wen) begin
      nm_mem[bus.nm_addr] = bus.nm_wdata;
      wr_log[8'(wr_n)] = bus.nm_addr;
      wr_n++;
    end
  end

  function automatic logic [L*N-1:0] pk(input int a, input int b, input int c, input int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic logic [L*W-1:0] wk(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preset(input int addr, input logic [L*N-1:0] data);
    pre_we   = 1'b1;
    pre_addr = 10'(addr);
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Called at a negedge with the engine idle; lat is the cycle (after the
  // handshake edge) in which done is seen, 0 if it never arrives.
  task automatic run_event(input int x, input int y, input int ch, input bit hold,
                           output int lat, output int busy_n, output int rdy_n,
                           output int cerr_n);
    bus.evt_x     = 8'(x);
    bus.evt_y     = 8'(y);
    bus.evt_ch    = 1'(ch);
    bus.evt_valid = 1'b1;
    lat = 0; busy_n = 0; rdy_n = 0; cerr_n = 0;
    @(negedge clk);
    if (!hold) bus.evt_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (bus.busy)      busy_n++;
      if (bus.evt_ready) rdy_n++;
      if (bus.coord_err) cerr_n++;
      if (bus.done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    if (!hold) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bn, rn, cn, w0, r0, k0, seen;
    int exp_wr [4];
    int exp_kw [4];
    int exp_v  [4];

    for (int p = 0; p < 9; p++) begin
      kw_mem[p]     = wk(p + 1, p + 1, p + 1, p + 1);
      kw_mem[9 + p] = wk(1, 1, 1, 1);
    end
    bus.evt_valid = 1'b0;
    bus.evt_x     = '0;
    bus.evt_y     = '0;
    bus.evt_ch    = '0;
    pre_clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);

    check("rst_evt_ready", bus.evt_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_coord_err", bus.coord_err, 0);
    check("rst_nm_wen", bus.nm_wen, 0);
    check("rst_kw_en", bus.kw_en, 0);
    check("rst_nm_addr", bus.nm_addr, 0);
    rst = 1'b0; pre_clr = 1'b0;
    @(negedge clk);

    // Interior event, all weights +1
    w0 = wr_n; r0 = rd_n; k0 = kw_n;
    run_event(10, 10, 1, 0, lat, bn, rn, cn);
    check("int_latency", lat, 19);
    check("int_busy_cycles", bn, 19);
    check("int_ready_while_busy", rn, 0);
    check("int_coord_err", cn, 0);
    check("int_writes", wr_n - w0, 9);
    check("int_reads", rd_n - r0, 9);
    for (int i = 0; i < 9; i++)
      check("int_wr_addr", wr_log[8'(w0 + i)], (9 + i / 3) * 32 + 9 + i % 3);
    check("int_kw_first", kw_log[8'(k0)], 9);
    check("int_kw_last", kw_log[8'(k0 + 8)], 17);
    check("int_data_297", nm_mem[297], pk(1, 1, 1, 1));
    check("int_data_363", nm_mem[363], pk(1, 1, 1, 1));

    // Corner event: only the (1..2, 1..2) kernel taps land in the map
    w0 = wr_n; r0 = rd_n; k0 = kw_n;
    run_event(0, 0, 0, 0, lat, bn, rn, cn);
    check("corner_latency", lat, 14);
    check("corner_writes", wr_n - w0, 4);
    check("corner_reads", rd_n - r0, 4);
    check("corner_kw_reads", kw_n - k0, 4);
    exp_wr = '{0, 1, 32, 33};
    exp_kw = '{4, 5, 7, 8};
    exp_v  = '{5, 6, 8, 9};
    for (int i = 0; i < 4; i++) begin
      check("corner_wr_addr", wr_log[8'(w0 + i)], exp_wr[i]);
      check("corner_kw_addr", kw_log[8'(k0 + i)], exp_kw[i]);
      check("corner_data", nm_mem[exp_wr[i]], pk(exp_v[i], exp_v[i], exp_v[i], exp_v[i]));
    end

    // Saturation and exact-boundary sums, per lane
    for (int p = 0; p < 9; p++) kw_mem[9 + p] = wk(5, -20, 3, -7);
    preset(660, pk(254, -250, 100, -100));
    preset(661, pk(-256, 255, 252, -249));
    run_event(20, 20, 1, 0, lat, bn, rn, cn);
    check("sat_latency", lat, 19);
    check("sat_clamp_660", nm_mem[660], pk(255, -256, 103, -107));
    check("sat_edge_661", nm_mem[661], pk(-251, 235, 255, -256));
    check("sat_plain_659", nm_mem[659], pk(5, -20, 3, -7));

    // Back-to-back with evt_valid held high
    w0 = wr_n;
    run_event(15, 15, 1, 1, lat, bn, rn, cn);
    check("b2b_a_latency", lat, 19);
    check("b2b_a_ready_low", rn, 0);
    bus.evt_x = 8'd16;
    bus.evt_y = 8'd16;
    @(negedge clk);
    check("b2b_idle_ready", bus.evt_ready, 1);
    check("b2b_idle_busy", bus.busy, 0);
    run_event(16, 16, 1, 0, lat, bn, rn, cn);
    check("b2b_b_latency", lat, 19);
    check("b2b_writes", wr_n - w0, 18);
    check("b2b_a_first", wr_log[8'(w0)], 14 * 32 + 14);
    check("b2b_b_first", wr_log[8'(w0 + 9)], 15 * 32 + 15);

    // Reset after the third write of an event
    w0 = wr_n;
    bus.evt_x = 8'd10; bus.evt_y = 8'd10; bus.evt_ch = 1'b0;
    bus.evt_valid = 1'b1;
    @(negedge clk);
    bus.evt_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (wr_n - w0 >= 3) begin
        seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("rstmid_reached_3_writes", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_ready", bus.evt_ready, 1);
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_wen", bus.nm_wen, 0);
    repeat (5) @(negedge clk);
    check("rstmid_no_more_writes", wr_n - w0, 3);
    w0 = wr_n;
    run_event(5, 5, 0, 0, lat, bn, rn, cn);
    check("rstmid_next_latency", lat, 19);
    check("rstmid_next_writes", wr_n - w0, 9);

    // Out-of-range coordinates: immediate done with coord_err, no accesses
    w0 = wr_n; r0 = rd_n; k0 = kw_n;
    run_event(32, 5, 0, 0, lat, bn, rn, cn);
    check("oob_x_latency", lat, 1);
    check("oob_x_coord_err", cn, 1);
    check("oob_x_busy", bn, 1);
    run_event(5, 32, 1, 0, lat, bn, rn, cn);
    check("oob_y_latency", lat, 1);
    check("oob_y_coord_err", cn, 1);
    check("oob_no_writes", wr_n - w0, 0);
    check("oob_no_reads", rd_n - r0, 0);
    check("oob_no_kw_reads", kw_n - k0, 0);
    check("oob_ready_after", bus.evt_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
